// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: single-step / run / breakpoint controller for a small CPU.
// Synchronizes and debounces the step switch, synchronizes the run switch,
// and sequences a HALT/STEP/RUN/BREAK state machine that gates the datapath
// clock enable and counts executed instructions.
//
// Ports:
//   clk_2       in   system clock, all state changes on rising edge
//   reset       in   asynchronous active-high reset
//   step_sw     in   raw step switch
//   run_sw      in   raw run switch
//   pc          in   [NBITS_TOP] datapath program counter
//   bp_addr     in   [NBITS_TOP] breakpoint address
//   cpu_en      out  datapath clock enable
//   mode        out  [2] state code HALT=0 STEP=1 RUN=2 BREAK=3
//   instr_count out  [16] enabled cycles since reset, wraps
//   bp_led      out  high while in BREAK
//
// Build option: define CPU_STEP_CTRL_BREAKPOINT_EN to include the
// breakpoint compare; without it bp_addr is ignored and BREAK is unreachable.

module cpu_step_ctrl #(
    parameter int NBITS_TOP       = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 step_sw,
    input  logic                 run_sw,
    input  logic [NBITS_TOP-1:0] pc,
    input  logic [NBITS_TOP-1:0] bp_addr,
    output logic                 cpu_en,
    output logic [1:0]           mode,
    output logic [15:0]          instr_count,
    output logic                 bp_led
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    // Count value at which the next differing cycle commits the new level.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       step_s1_q, step_s2_q;
    logic       run_s1_q, run_s2_q;
    logic       deb_q, deb_d;
    logic       deb_dly_q;
    logic       pulse_q, pulse_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    state_t     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic run_lvl;
    logic bp_hit;

    assign run_lvl = run_s2_q;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    // Combinational so the instruction at bp_addr is held back this cycle.
    assign bp_hit = (state_q == S_RUN) && (pc == bp_addr);
    assign bp_led = (state_q == S_BREAK);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
    assign bp_hit    = 1'b0;
    assign bp_led    = 1'b0;
`endif

    assign cpu_en      = (state_q == S_STEP) ||
                         ((state_q == S_RUN) && !bp_hit);
    assign mode        = state_q;
    assign instr_count = cnt_q;

    // Debounce: any cycle where the synchronized level agrees with the
    // accepted level clears the run of differing cycles.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (step_s2_q != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = step_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    // Registered rising-edge detect of the debounced level.
    assign pulse_d = deb_q && !deb_dly_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALT: begin
                if (run_lvl) begin
                    state_d = S_RUN;
                end else if (pulse_q) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            S_RUN: begin
                if (!run_lvl) begin
                    state_d = S_HALT;
                end else if (bp_hit) begin
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (pulse_q) begin
                    state_d = S_STEP;
                end else if (!run_lvl) begin
                    state_d = S_HALT;
                end
            end
        endcase
    end

    assign cnt_d = cnt_q + {15'd0, cpu_en};

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            pulse_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= S_HALT;
            cnt_q     <= '0;
        end else begin
            step_s1_q <= step_sw;
            step_s2_q <= step_s1_q;
            run_s1_q  <= run_sw;
            run_s2_q  <= run_s1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            pulse_q   <= pulse_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and randomized checks of cpu_step_ctrl
// against a behavioural model built from input histories.

module tb_cpu_step_ctrl;

    localparam int DB = 4;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk_2   = 1'b0;
    logic        reset   = 1'b1;
    logic        step_sw = 1'b0;
    logic        run_sw  = 1'b0;
    logic [7:0]  pc      = 8'd0;
    logic [7:0]  bp_addr = 8'hFF;
    logic        cpu_en;
    logic [1:0]  mode;
    logic [15:0] instr_count;
    logic        bp_led;

    cpu_step_ctrl #(.NBITS_TOP(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .step_sw     (step_sw),
        .run_sw      (run_sw),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .mode        (mode),
        .instr_count (instr_count),
        .bp_led      (bp_led)
    );

    always #5 clk_2 = ~clk_2;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit pc_hold  = 1'b0;

    // Model: raw-sample histories plus a mode number driven by the rules.
    int          m_st;
    logic [15:0] m_cnt;
    logic        m_s1;
    logic        m_s2h [16];
    logic        m_r1, m_r2;
    logic        m_dh [3];

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic bit m_hit();
        return BP_EN && (m_st == 2) && (pc == bp_addr);
    endfunction

    function automatic bit m_cpu();
        return (m_st == 1) || ((m_st == 2) && !m_hit());
    endfunction

    task automatic m_reset();
        m_st  = 0;
        m_cnt = 16'd0;
        m_s1  = 1'b0;
        m_r1  = 1'b0;
        m_r2  = 1'b0;
        for (int i = 0; i < 16; i++) m_s2h[i] = 1'b0;
        for (int i = 0; i < 3; i++) m_dh[i] = 1'b0;
    endtask

    task automatic m_edge(output bit en);
        bit pulse, run, hit, all_diff;
        int nx;
        pulse = m_dh[1] && !m_dh[2];
        run   = m_r2;
        hit   = m_hit();
        en    = m_cpu();
        nx    = m_st;
        case (m_st)
            0: if (run) nx = 2; else if (pulse) nx = 1;
            1: nx = 0;
            2: if (!run) nx = 0; else if (hit) nx = 3;
            default: if (pulse) nx = 1; else if (!run) nx = 0;
        endcase
        m_st = nx;
        if (en) m_cnt = m_cnt + 16'd1;
        // New level accepted once the last DB synchronized samples all differ.
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++)
            if (m_s2h[i] == m_dh[0]) all_diff = 1'b0;
        m_dh[2] = m_dh[1];
        m_dh[1] = m_dh[0];
        if (all_diff) m_dh[0] = !m_dh[0];
        for (int i = 15; i > 0; i--) m_s2h[i] = m_s2h[i-1];
        m_s2h[0] = m_s1;
        m_s1     = step_sw;
        m_r2     = m_r1;
        m_r1     = run_sw;
    endtask

    task automatic tick();
        bit en;
        @(posedge clk_2);
        #1;
        if (reset) begin
            m_reset();
        end else begin
            m_edge(en);
            if (en && !pc_hold) pc = pc + 8'd1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk_2) begin
        if (chk_en) begin
            check("cpu_en", cpu_en, m_cpu());
            check("mode", mode, m_st);
            check("bp_led", bp_led, BP_EN && (m_st == 3));
            check("instr_count", instr_count, m_cnt);
        end
    end

    int first, npulse, n;

    initial begin
        m_reset();
        #2;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_mode", mode, 0);
        check("rst_count", instr_count, 0);
        check("rst_bp_led", bp_led, 0);
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Single step, held switch.
        step_sw = 1'b1;
        first   = -1;
        npulse  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_en) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check("step_latency", first, 8);
        check("step_pulses", npulse, 1);
        check("step_count", instr_count, 1);
        check("step_mode", mode, 0);
        step_sw = 1'b0;
        repeat (10) tick();

        // Short glitch is rejected.
        do_reset();
        step_sw = 1'b1;
        repeat (3) tick();
        step_sw = 1'b0;
        npulse  = 0;
        repeat (20) begin
            tick();
            if (cpu_en) npulse++;
        end
        check("glitch_pulses", npulse, 0);
        check("glitch_count", instr_count, 0);

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        do_reset();
        pc      = 8'd0;
        bp_addr = 8'h05;
        run_sw  = 1'b1;
        n = 0;
        while (mode != 2'd3 && n < 40) begin
            tick();
            n++;
        end
        check("bp_mode", mode, 3);
        check("bp_pc", pc, 5);
        check("bp_cpu_en", cpu_en, 0);
        check("bp_led_on", bp_led, 1);
        check("bp_count", instr_count, 5);
        step_sw = 1'b1;
        n = 0;
        while (mode != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_step_mode", mode, 1);
        check("bp_step_en", cpu_en, 1);
        step_sw = 1'b0;
        tick();
        check("bp_step_pc", pc, 6);
        check("bp_after_mode", mode, 0);
        tick();
        check("bp_resume_mode", mode, 2);
`else
        do_reset();
        pc      = 8'd0;
        bp_addr = 8'h05;
        run_sw  = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            check("nobp_cpu_en", cpu_en, 1);
            check("nobp_led", bp_led, 0);
            tick();
        end
        check("nobp_pc", pc, 8);
`endif
        run_sw = 1'b0;
        repeat (6) tick();

        // Asynchronous reset in the middle of RUN.
        do_reset();
        bp_addr = 8'hFF;
        pc      = 8'd0;
        run_sw  = 1'b1;
        repeat (6) tick();
        check("arst_pre_mode", mode, 2);
        @(posedge clk_2);
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_mode", mode, 0);
        check("arst_count", instr_count, 0);
        run_sw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();

        // Step held high through reset gives exactly one step.
        step_sw = 1'b1;
        do_reset();
        npulse = 0;
        repeat (20) begin
            tick();
            if (cpu_en) npulse++;
        end
        check("held_rst_pulses", npulse, 1);
        step_sw = 1'b0;
        repeat (10) tick();

        // Counter wrap.
        do_reset();
        pc_hold = 1'b1;
        pc      = 8'h10;
        bp_addr = 8'h20;
        run_sw  = 1'b1;
        n = 0;
        while (m_cnt != 16'hFFFE && n < 70000) begin
            tick();
            n++;
        end
        check("wrap_fffe", instr_count, 16'hFFFE);
        tick();
        check("wrap_ffff", instr_count, 16'hFFFF);
        tick();
        check("wrap_0000", instr_count, 16'h0000);
        tick();
        check("wrap_0001", instr_count, 16'h0001);
        pc_hold = 1'b0;
        run_sw  = 1'b0;
        repeat (4) tick();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) step_sw = ~step_sw;
            if ($urandom_range(39, 0) == 0) run_sw = ~run_sw;
            if ($urandom_range(29, 0) == 0)
                bp_addr = pc + 8'($urandom_range(6, 1));
            if ($urandom_range(199, 0) == 0)
                pc = 8'($urandom_range(255, 0));
            if ($urandom_range(599, 0) == 0) do_reset();
            tick();
        end

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
